qspi_slave_target: RTL and testbench

- Synthesizable QSPI target (slave) sitting directly downstream of the QSPI master on the chip_select/sclk/IO[3:0] bus.
- Oversamples the bus in the sys_clk domain and supports SPI, Dual and Quad lane modes, SPI mode 0 only (CPOL=0, CPHA=0).
- Master write (operation=1): deserialises one DATA_WIDTH word and delivers it over a valid/ready handshake.
- Master read (operation=0): serialises a word supplied by local logic.
- Replaces the behavioural slave model in the master bench and serves as the on-chip register-port front end.

---
 rtl/qspi_pkg.sv | 29 ++
 rtl/qspi_sync_edge.sv | 31 +++
 rtl/qspi_slave_target.sv | 249 ++++++++++++++++++++++++
 tb/tb_qspi_slave_target.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI target.
// Lane modes, operation codes, target states and lane count.
package qspi_pkg;

    typedef enum logic [1:0] {
        SPI  = 2'b00,
        DUAL = 2'b01,
        QUAD = 2'b10,
        RSVD = 2'b11
    } sel_mode_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    function automatic logic [2:0] lanes(input sel_mode_t m);
        case (m)
            DUAL:    return 3'd2;
            QUAD:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Synchroniser chain with rise/fall pulse detection.
// Pulses are one sys_clk wide and aligned to the synchronised level.
module qspi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // shift the async input through the chain, keep last synced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/qspi_slave_target.sv
// QSPI target: oversampled SPI/Dual/Quad, mode 0 only.
// Receives one word on master write, returns one on master read.
module qspi_slave_target
    import qspi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  nrst,
    input  logic [1:0]            sel_mode,
    input  logic                  operation,
    input  logic                  chip_select,
    input  logic                  sclk,
    input  logic [3:0]            io_in,
    output logic [3:0]            io_out,
    output logic [3:0]            io_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_taken,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  abort,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int W  = DATA_WIDTH;

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;

    logic [3:0] io_chain [SYNC_STAGES];
    logic [3:0] io_s;

    state_t    state, state_d;
    sel_mode_t mode_q;
    logic      op_q;

    logic [CW-1:0] grp_cnt;
    logic [CW-1:0] grp_total;
    logic [W-1:0]  rx_sh;
    logic [W-1:0]  rx_next;
    logic [W-1:0]  tx_sh;

    logic start, cnt_step, tx_step;
    logic rx_done, rx_load, abort_d;

    qspi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk   (sys_clk),
        .rst_n (nrst),
        .d     (chip_select),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    qspi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sclk_sync (
        .clk   (sys_clk),
        .rst_n (nrst),
        .d     (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // io lanes synchronised with the same depth as sclk
    always_ff @(posedge sys_clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                io_chain[i] <= '0;
            end
        end else begin
            io_chain[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                io_chain[i] <= io_chain[i-1];
            end
        end
    end

    assign io_s = io_chain[SYNC_STAGES-1];

    // groups per word for the latched mode
    always_comb begin
        grp_total = CW'(W);
        case (mode_q)
            DUAL:    grp_total = CW'(W / 2);
            QUAD:    grp_total = CW'(W / 4);
            default: grp_total = CW'(W);
        endcase
    end

    // rx shifter with the current group appended, IO0 most significant
    always_comb begin
        rx_next = (rx_sh << 1) | W'(io_s[0]);
        case (mode_q)
            DUAL:    rx_next = (rx_sh << 2)
                             | W'({io_s[0], io_s[1]});
            QUAD:    rx_next = (rx_sh << 4)
                             | W'({io_s[0], io_s[1],
                                   io_s[2], io_s[3]});
            default: rx_next = (rx_sh << 1) | W'(io_s[0]);
        endcase
    end

    // state register
    always_ff @(posedge sys_clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next-state and per-cycle strobes
    always_comb begin
        state_d  = state;
        start    = 1'b0;
        cnt_step = 1'b0;
        tx_step  = 1'b0;
        rx_done  = 1'b0;
        abort_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    start   = 1'b1;
                    state_d = (sel_mode == RSVD) ? WAIT_CS : SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    cnt_step = 1'b1;
                    if (grp_cnt == grp_total - CW'(1)) begin
                        state_d = WAIT_CS;
                        rx_done = (op_q == OP_WRITE);
                    end
                end else if (sclk_fall && op_q == OP_READ) begin
                    tx_step = 1'b1;
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // transaction setup, group counter and tx shifter
    always_ff @(posedge sys_clk or negedge nrst) begin
        if (!nrst) begin
            mode_q   <= SPI;
            op_q     <= OP_READ;
            grp_cnt  <= '0;
            tx_sh    <= '0;
            tx_taken <= 1'b0;
            abort    <= 1'b0;
        end else begin
            tx_taken <= 1'b0;
            abort    <= abort_d;
            if (start) begin
                mode_q  <= sel_mode_t'(sel_mode);
                op_q    <= operation;
                grp_cnt <= '0;
                if (operation == OP_READ && sel_mode != RSVD) begin
                    tx_sh    <= tx_data;
                    tx_taken <= 1'b1;
                end
            end else begin
                if (cnt_step) begin
                    grp_cnt <= grp_cnt + CW'(1);
                end
                if (tx_step) begin
                    tx_sh <= tx_sh << lanes(mode_q);
                end
            end
        end
    end

    assign rx_load = rx_done && (!rx_valid || rx_ready);

    // rx shifter, delivery handshake and sticky overrun
    always_ff @(posedge sys_clk or negedge nrst) begin
        if (!nrst) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (start) begin
                rx_sh <= '0;
            end else if (cnt_step && op_q == OP_WRITE) begin
                rx_sh <= rx_next;
            end
            if (rx_load) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (overrun_clr) begin
                overrun <= 1'b0;
            end else if (rx_done && !rx_load) begin
                overrun <= 1'b1;
            end
        end
    end

    // lane drive: only while shifting out a read
    always_comb begin
        io_oe  = 4'b0000;
        io_out = 4'b0000;
        if (state == SHIFT && op_q == OP_READ) begin
            case (mode_q)
                SPI: begin
                    io_oe     = 4'b0010;
                    io_out[1] = tx_sh[W-1];
                end
                DUAL: begin
                    io_oe     = 4'b0011;
                    io_out[0] = tx_sh[W-1];
                    io_out[1] = tx_sh[W-2];
                end
                QUAD: begin
                    io_oe  = 4'b1111;
                    io_out = {tx_sh[W-4], tx_sh[W-3],
                              tx_sh[W-2], tx_sh[W-1]};
                end
                default: begin
                    io_oe  = 4'b0000;
                    io_out = 4'b0000;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_qspi_slave_target.sv
// Bench for qspi_slave_target: bit-banged master plus a
// transaction-level model of what the target must deliver.
module tb_qspi_slave_target;

    localparam int W  = 8;
    localparam int PH = 6;

    logic         sys_clk = 1'b0;
    logic         nrst = 1'b0;
    logic [1:0]   sel_mode = 2'b00;
    logic         operation = 1'b0;
    logic         chip_select = 1'b1;
    logic         sclk = 1'b0;
    logic [3:0]   io_in = 4'h0;
    logic [3:0]   io_out;
    logic [3:0]   io_oe;
    logic [W-1:0] tx_data = '0;
    logic         tx_taken;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         overrun;
    logic         overrun_clr = 1'b0;
    logic         abort;
    logic         busy;

    qspi_slave_target #(
        .DATA_WIDTH  (W),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk     (sys_clk),
        .nrst        (nrst),
        .sel_mode    (sel_mode),
        .operation   (operation),
        .chip_select (chip_select),
        .sclk        (sclk),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oe       (io_oe),
        .tx_data     (tx_data),
        .tx_taken    (tx_taken),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .abort       (abort),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr = 1'b0;
    logic [W-1:0] exp_rx [$];
    logic [3:0]   exp_mask = 4'h0;
    int           n_taken = 0;
    int           n_abort = 0;
    int           n_rx = 0;
    logic [W-1:0] last_rx = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic int lanes_of(input int mode);
        if (mode == 1) return 2;
        if (mode == 2) return 4;
        return 1;
    endfunction

    function automatic logic [3:0] mask_of(input int mode);
        if (mode == 0) return 4'b0010;
        if (mode == 1) return 4'b0011;
        if (mode == 2) return 4'b1111;
        return 4'b0000;
    endfunction

    // per-cycle checks against the model
    always @(negedge sys_clk) begin
        if (nrst) begin
            chk("oe_shape", {31'd0, (io_oe == 4'h0 || io_oe == exp_mask)}, 1);
            chk("out_masked", {28'd0, io_out & ~io_oe}, 0);
            if (!busy) chk("oe_idle", {28'd0, io_oe}, 0);
            if (rx_valid) chk("rx_hold", {24'd0, rx_data}, {24'd0, m_data});
            if (rx_valid && rx_ready) begin
                n_rx++;
                last_rx = rx_data;
                chk("rx_expected", {31'd0, exp_rx.size() > 0}, 1);
                if (exp_rx.size() > 0)
                    chk("rx_word", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
            if (tx_taken) n_taken++;
            if (abort) n_abort++;
        end
    end

    task automatic master_write(input int mode, input logic [W-1:0] word,
                                input int groups);
        int L;
        int G;
        L = lanes_of(mode);
        G = W / L;
        sel_mode = mode[1:0];
        operation = 1'b1;
        exp_mask = 4'h0;
        wait_cyc(2);
        chip_select = 1'b0;
        for (int g = 0; g < groups; g++) begin
            io_in = 4'h0;
            for (int k = 0; k < L; k++) io_in[k] = word[W-1-g*L-k];
            wait_cyc(PH);
            sclk = 1'b1;
            if (g == G - 1 && mode != 3) begin
                if (!m_valid || rx_ready) begin
                    m_data = word;
                    exp_rx.push_back(word);
                    m_valid = !rx_ready;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            wait_cyc(PH);
            sclk = 1'b0;
        end
        wait_cyc(PH);
        chk("busy_in_txn", {31'd0, busy}, 1);
        chip_select = 1'b1;
        wait_cyc(10);
        chk("busy_after_cs", {31'd0, busy}, 0);
    endtask

    task automatic master_read(input int mode, input logic [3:0] exp_oe,
                               output logic [W-1:0] rd);
        int L;
        int G;
        int lane;
        L = lanes_of(mode);
        G = W / L;
        sel_mode = mode[1:0];
        operation = 1'b0;
        exp_mask = mask_of(mode);
        rd = '0;
        wait_cyc(2);
        chip_select = 1'b0;
        for (int g = 0; g < G; g++) begin
            wait_cyc(PH);
            sclk = 1'b1;
            if (g == 0) chk("rd_oe", {28'd0, io_oe}, {28'd0, exp_oe});
            for (int k = 0; k < L; k++) begin
                lane = (mode == 0) ? 1 : k;
                rd[W-1-g*L-k] = io_out[lane] & io_oe[lane];
            end
            wait_cyc(PH);
            sclk = 1'b0;
        end
        wait_cyc(PH);
        chk("busy_in_rd", {31'd0, busy}, 1);
        chip_select = 1'b1;
        wait_cyc(10);
        exp_mask = 4'h0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_io_out"}, {28'd0, io_out}, 0);
        chk({tag, "_io_oe"}, {28'd0, io_oe}, 0);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 0);
        chk({tag, "_tx_taken"}, {31'd0, tx_taken}, 0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 0);
        chk({tag, "_abort"}, {31'd0, abort}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        logic [W-1:0] rd;
        int t0;
        int a0;
        int r0;

        wait_cyc(3);
        chk_reset_outputs("rst");
        nrst = 1'b1;
        wait_cyc(3);
        chk_reset_outputs("post_rst");

        // SPI write, consumer always ready
        rx_ready = 1'b1;
        r0 = n_rx;
        master_write(0, 8'hA5, 8);
        chk("spi_wr_count", n_rx - r0, 1);
        chk("spi_wr_data", {24'd0, last_rx}, 32'hA5);
        chk("spi_wr_valid_clr", {31'd0, rx_valid}, 0);

        // Dual then Quad with consumer stalled
        rx_ready = 1'b0;
        master_write(1, 8'h5A, 4);
        chk("dual_valid", {31'd0, rx_valid}, 1);
        chk("dual_data", {24'd0, rx_data}, 32'h5A);
        chk("dual_no_ovr", {31'd0, overrun}, 0);
        master_write(2, 8'hF0, 2);
        chk("quad_ovr", {31'd0, overrun}, 1);
        chk("quad_ovr_model", {31'd0, overrun}, {31'd0, m_ovr});
        chk("quad_keep_data", {24'd0, rx_data}, 32'h5A);
        chk("quad_keep_valid", {31'd0, rx_valid}, 1);
        overrun_clr = 1'b1;
        m_ovr = 1'b0;
        wait_cyc(1);
        overrun_clr = 1'b0;
        wait_cyc(1);
        chk("ovr_clr", {31'd0, overrun}, 0);
        r0 = n_rx;
        rx_ready = 1'b1;
        m_valid = 1'b0;
        wait_cyc(3);
        chk("drain_count", n_rx - r0, 1);
        chk("drain_data", {24'd0, last_rx}, 32'h5A);
        chk("drain_valid", {31'd0, rx_valid}, 0);
        chk("drain_queue", exp_rx.size(), 0);

        // reads in all three lane modes
        tx_data = 8'hC3;
        t0 = n_taken;
        master_read(0, 4'b0010, rd);
        chk("spi_rd", {24'd0, rd}, 32'hC3);
        chk("spi_taken", n_taken - t0, 1);
        t0 = n_taken;
        master_read(1, 4'b0011, rd);
        chk("dual_rd", {24'd0, rd}, 32'hC3);
        chk("dual_taken", n_taken - t0, 1);
        t0 = n_taken;
        master_read(2, 4'b1111, rd);
        chk("quad_rd", {24'd0, rd}, 32'hC3);
        chk("quad_taken", n_taken - t0, 1);

        // abort after one of two quad groups
        a0 = n_abort;
        r0 = n_rx;
        master_write(2, 8'h77, 1);
        chk("abort_pulse", n_abort - a0, 1);
        chk("abort_no_rx", n_rx - r0, 0);
        chk("abort_valid", {31'd0, rx_valid}, 0);
        master_write(2, 8'h3C, 2);
        chk("post_abort_count", n_rx - r0, 1);
        chk("post_abort_data", {24'd0, last_rx}, 32'h3C);

        // reserved mode: nothing driven or received
        r0 = n_rx;
        t0 = n_taken;
        master_write(3, 8'hFF, 8);
        chk("rsvd_wr_no_rx", n_rx - r0, 0);
        master_read(3, 4'b0000, rd);
        chk("rsvd_rd_no_take", n_taken - t0, 0);
        chk("rsvd_no_ovr", {31'd0, overrun}, 0);

        // reset in the middle of an SPI read
        tx_data = 8'h96;
        t0 = n_taken;
        sel_mode = 2'b00;
        operation = 1'b0;
        exp_mask = mask_of(0);
        wait_cyc(2);
        chip_select = 1'b0;
        repeat (3) begin
            wait_cyc(PH);
            sclk = 1'b1;
            wait_cyc(PH);
            sclk = 1'b0;
        end
        chk("mid_rd_oe", {28'd0, io_oe}, 32'h2);
        chk("mid_rd_taken", n_taken - t0, 1);
        nrst = 1'b0;
        m_data = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        exp_rx.delete();
        #1;
        chk_reset_outputs("mid_rst");
        chip_select = 1'b1;
        sclk = 1'b0;
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(5);
        exp_mask = 4'h0;
        tx_data = 8'h69;
        t0 = n_taken;
        master_read(0, 4'b0010, rd);
        chk("after_rst_rd", {24'd0, rd}, 32'h69);
        chk("after_rst_taken", n_taken - t0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
